// File: rtl/jk_cmd_sequencer.sv
// Queues J/K commands and drives a jkff for cnt+1 cycles each, checking fed-back q against an internal JK model.
// j/k move one edge after a command lands in an empty FIFO; cmd_ready drops only while the FIFO is full.
module jk_cmd_fifo #(
  parameter int W     = 6,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_vld,
  output logic         wr_rdy,
  input  logic [W-1:0] wr_dat,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         full;
  logic         empty;

  // Extra pointer bit separates full from empty when the index bits match.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_rdy = !full;
  assign rd_vld = !empty;
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_vld && wr_rdy) begin
      mem[wr_ptr[AW-1:0]] <= wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_vld && wr_rdy) wr_ptr <= wr_ptr + 1'b1;
      if (rd_vld && rd_rdy) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

module jk_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             j,
  output logic             k,
  input  logic             q_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       err_cnt
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   rem;
  logic [CNT_W-1:0]   rem_nxt;
  logic               j_nxt;
  logic               k_nxt;
  logic               pop;
  logic               fifo_vld;
  logic [CNT_W+1:0]   fifo_dat;
  logic               exp_q;
  logic               exp_valid;

  jk_cmd_fifo #(.W(CNT_W + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (cmd_valid),
    .wr_rdy (cmd_ready),
    .wr_dat ({cmd_op, cmd_cnt}),
    .rd_vld (fifo_vld),
    .rd_rdy (pop),
    .rd_dat (fifo_dat)
  );

  assign busy = (state == RUN);
  assign done = busy && (rem == '0);

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    j_nxt     = j;
    k_nxt     = k;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        j_nxt = 1'b0;
        k_nxt = 1'b0;
        if (fifo_vld) begin
          pop       = 1'b1;
          j_nxt     = fifo_dat[CNT_W+1];
          k_nxt     = fifo_dat[CNT_W];
          rem_nxt   = fifo_dat[CNT_W-1:0];
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (rem != '0) begin
          rem_nxt = rem - 1'b1;
        end else if (fifo_vld) begin
          // Back-to-back commands: reload in the last cycle so there is no idle bubble.
          pop     = 1'b1;
          j_nxt   = fifo_dat[CNT_W+1];
          k_nxt   = fifo_dat[CNT_W];
          rem_nxt = fifo_dat[CNT_W-1:0];
        end else begin
          j_nxt     = 1'b0;
          k_nxt     = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      rem       <= '0;
      j         <= 1'b0;
      k         <= 1'b0;
      exp_q     <= 1'b0;
      exp_valid <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      j     <= j_nxt;
      k     <= k_nxt;
      // Model advances on the same edge the flip-flop samples the registered j/k.
      exp_q <= (j & ~exp_q) | (~k & exp_q);
      if (j != k) exp_valid <= 1'b1;
      if (exp_valid && (q_in != exp_q)) begin
        err <= 1'b1;
        if (err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Randomized scoreboard bench for jk_cmd_sequencer with a behavioural jkff on the feedback path.
module tb_jk_cmd_sequencer;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_cnt = '0;
  logic             j, k, q_in, busy, done, err;
  logic [7:0]       err_cnt;

  logic       ff_q = 1'b0;
  logic       tie0 = 1'b0;
  logic       mon_en = 1'b0;
  logic [2:0] mon_e;
  logic [2:0] exp_drv [$];

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int first_busy = -1;
  int last_busy = -1;
  int busy_cycles = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  jk_cmd_sequencer #(.FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_cnt   (cmd_cnt),
    .j         (j),
    .k         (k),
    .q_in      (q_in),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  // Attached flip-flop; tie0 models a stuck-low q.
  always @(posedge clk) begin
    case ({j, k})
      2'b01:   ff_q <= 1'b0;
      2'b10:   ff_q <= 1'b1;
      2'b11:   ff_q <= ~ff_q;
      default: ff_q <= ff_q;
    endcase
  end
  assign q_in = tie0 ? 1'b0 : ff_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every busy cycle must match the next expected {j,k,done} drive slot.
  always @(negedge clk) begin
    ncyc++;
    if (mon_en) begin
      if (busy) begin
        busy_cycles++;
        if (first_busy < 0) first_busy = ncyc;
        last_busy = ncyc;
        if (done) done_cnt++;
        if (exp_drv.size() == 0) begin
          chk("unexpected_busy", {31'd0, busy}, 32'd0);
        end else begin
          mon_e = exp_drv.pop_front();
          chk("drive_jk_done", {29'd0, j, k, done}, {29'd0, mon_e});
        end
      end else begin
        chk("idle_jk_done", {29'd0, j, k, done}, 32'd0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_j"}, {31'd0, j}, 32'd0);
    chk({tag, "_k"}, {31'd0, k}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_err_cnt"}, {24'd0, err_cnt}, 32'd0);
    chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic do_reset(input logic tie);
    mon_en = 1'b0;
    reset  = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("rst_edge1");
    @(posedge clk); #1;
    check_reset_outputs("rst_edge2");
    tie0 = tie;
    exp_drv.delete();
    reset  = 1'b1;
    mon_en = 1'b1;
  endtask

  // Expected behaviour: commands run in push order, each for cnt+1 cycles, done in the last.
  task automatic push_cmd(input logic [1:0] op, input logic [CNT_W-1:0] cnt, output int stalls);
    logic acc;
    acc    = 1'b0;
    stalls = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    for (int t = 0; t < 100 && !acc; t++) begin
      acc = cmd_ready;
      @(posedge clk); #1;
      if (!acc) stalls++;
    end
    cmd_valid = 1'b0;
    if (acc) begin
      for (int i = 0; i <= int'(cnt); i++) exp_drv.push_back({op[1], op[0], i == int'(cnt)});
    end else begin
      chk("push_timeout", {31'd0, cmd_ready}, 32'd1);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((busy || exp_drv.size() != 0) && t < 600) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #1;
    chk("drain_busy", {31'd0, busy}, 32'd0);
    chk("drain_queue", exp_drv.size(), 32'd0);
  endtask

  initial begin
    int st;
    int st_sum;
    int total;
    int cnt_exp;
    int idle_bad;
    logic [1:0] rop;
    logic [CNT_W-1:0] rcnt;

    do_reset(1'b0);

    // SET x1 then TOG x4: q goes 1,0,1,0,1 with two done pulses.
    done_cnt = 0;
    push_cmd(2'b10, 4'd0, st);
    push_cmd(2'b11, 4'd3, st);
    drain();
    chk("t2_done_pulses", done_cnt, 32'd2);
    chk("t2_err", {31'd0, err}, 32'd0);
    chk("t2_q_end", {31'd0, q_in}, 32'd1);

    // Long SET then five more: the sixth waits until a slot frees, and pop alone does not admit it.
    first_busy  = -1;
    busy_cycles = 0;
    total  = 16;
    st_sum = 0;
    push_cmd(2'b10, 4'd15, st);
    for (int n = 0; n < 5; n++) begin
      rop  = 2'($urandom_range(0, 3));
      rcnt = CNT_W'($urandom_range(0, 15));
      push_cmd(rop, rcnt, st);
      if (n < 4) st_sum += st;
      total += int'(rcnt) + 1;
    end
    chk("t3_stall_first4", st_sum, 32'd0);
    // Full after 4 stored; first pop of a stored command happens at the 17th edge of the SET.
    chk("t3_stall_6th", st, 32'd13);
    drain();
    chk("t3_busy_cycles", busy_cycles, total);
    chk("t3_no_gap", last_busy - first_busy + 1, total);
    chk("t3_err", {31'd0, err}, 32'd0);

    // HOLD for 16 cycles after SET: q stays 1, one done for the HOLD.
    done_cnt = 0;
    push_cmd(2'b10, 4'd0, st);
    push_cmd(2'b00, 4'd15, st);
    drain();
    chk("t6_done_pulses", done_cnt, 32'd2);
    chk("t6_q", {31'd0, q_in}, 32'd1);
    chk("t6_err", {31'd0, err}, 32'd0);
    chk("t6_err_cnt", {24'd0, err_cnt}, 32'd0);

    // q stuck low: err two cycles after j rises, then one count per cycle up to 255.
    do_reset(1'b1);
    push_cmd(2'b10, 4'd2, st);
    for (int m = 1; m <= 300; m++) begin
      @(posedge clk);
      @(negedge clk);
      if (m <= 8 || m >= 250) begin
        cnt_exp = (m >= 3) ? ((m - 2 > 255) ? 255 : m - 2) : 0;
        chk("t4_err", {31'd0, err}, (m >= 3) ? 32'd1 : 32'd0);
        chk("t4_err_cnt", {24'd0, err_cnt}, cnt_exp);
      end
    end
    @(posedge clk); #1;

    // Reset mid-run with a loaded FIFO and saturated error state.
    push_cmd(2'b10, 4'd15, st);
    for (int n = 0; n < 3; n++) push_cmd(2'b00, 4'd5, st);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("t1_err_before", {31'd0, err}, 32'd1);
    do_reset(1'b0);
    repeat (20) @(negedge clk);

    // TOG cnt=10 with 3 queued; reset lands in the 4th drive cycle, queue must be dropped.
    push_cmd(2'b11, 4'd10, st);
    for (int n = 0; n < 3; n++) begin
      rop  = 2'($urandom_range(0, 3));
      rcnt = CNT_W'($urandom_range(0, 15));
      push_cmd(rop, rcnt, st);
    end
    @(posedge clk); #1;
    chk("t5_busy_before", {31'd0, busy}, 32'd1);
    do_reset(1'b0);
    idle_bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || j || k) idle_bad++;
    end
    chk("t5_idle_after", idle_bad, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
